// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped UART transmitter with a small TX FIFO, a
// programmable bit divisor and a sticky end-of-transmission interrupt.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IntReq,
    output logic        TxD
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]       r_rstSync;
    state_t           r_state;
    logic             r_txd;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitCnt;
    logic [15:0]      r_timer;
    logic [15:0]      r_divLatch;
    logic [15:0]      r_div;
    logic             r_ie;
    logic             r_ipend;
    logic             r_ovf;
    logic             r_intReq;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic        w_active;
    logic        w_wrData;
    logic        w_wrStatus;
    logic        w_wrCtrl;
    logic        w_wrDiv;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_push;
    logic        w_drop;
    logic        w_timerDone;
    logic [15:0] w_divEff;
    logic        w_unusedDin;

    state_t      w_nextState;
    logic        w_txdNext;
    logic [7:0]  w_shiftNext;
    logic [2:0]  w_bitCntNext;
    logic [15:0] w_timerNext;
    logic [15:0] w_divLatchNext;
    logic        w_pop;
    logic        w_setIpend;
    logic        w_frameStart;

    // Reset asserts asynchronously but its release is delayed two edges, so
    // nothing acts on an edge that coincides with a ragged release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rstSync <= 2'b00;
        else        r_rstSync <= {r_rstSync[0], 1'b1};
    end

    assign w_active    = r_rstSync[1];
    assign w_wrData    = w_active && WE && (Addr == 2'd0);
    assign w_wrStatus  = w_active && WE && (Addr == 2'd1);
    assign w_wrCtrl    = w_active && WE && (Addr == 2'd2);
    assign w_wrDiv     = w_active && WE && (Addr == 2'd3);
    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != IDLE);
    assign w_push      = w_wrData && (!w_full || w_pop);
    assign w_drop      = w_wrData && w_full && !w_pop;
    assign w_timerDone = (r_timer == 16'd0);
    assign w_divEff    = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_unusedDin = ^DIn[31:16];

    // Next-state logic: every state holds for the latched divisor, and a frame
    // start (from IDLE or straight out of STOP) pops the FIFO head.
    always_comb begin
        w_nextState    = r_state;
        w_txdNext      = r_txd;
        w_shiftNext    = r_shift;
        w_bitCntNext   = r_bitCnt;
        w_timerNext    = r_timer;
        w_divLatchNext = r_divLatch;
        w_pop          = 1'b0;
        w_setIpend     = 1'b0;
        w_frameStart   = 1'b0;
        case (r_state)
            IDLE: begin
                w_txdNext = 1'b1;
                if (w_active && !w_empty) w_frameStart = 1'b1;
            end
            START: begin
                if (w_timerDone) begin
                    w_nextState = DATA;
                    w_txdNext   = r_shift[0];
                    w_timerNext = r_divLatch - 16'd1;
                end else begin
                    w_timerNext = r_timer - 16'd1;
                end
            end
            DATA: begin
                if (w_timerDone) begin
                    w_timerNext = r_divLatch - 16'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_nextState = STOP;
                        w_txdNext   = 1'b1;
                    end else begin
                        w_shiftNext  = {1'b0, r_shift[7:1]};
                        w_txdNext    = r_shift[1];
                        w_bitCntNext = r_bitCnt + 3'd1;
                    end
                end else begin
                    w_timerNext = r_timer - 16'd1;
                end
            end
            STOP: begin
                if (w_timerDone) begin
                    if (!w_empty) begin
                        w_frameStart = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                        w_setIpend  = 1'b1;
                        w_txdNext   = 1'b1;
                    end
                end else begin
                    w_timerNext = r_timer - 16'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_txdNext   = 1'b1;
            end
        endcase
        if (w_frameStart) begin
            w_pop          = 1'b1;
            w_nextState    = START;
            w_txdNext      = 1'b0;
            w_shiftNext    = r_mem[r_rdPtr];
            w_bitCntNext   = 3'd0;
            w_divLatchNext = w_divEff;
            w_timerNext    = w_divEff - 16'd1;
        end
    end

    // Transmitter state, shifter, bit timer and the registered serial line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_txd      <= 1'b1;
            r_shift    <= 8'd0;
            r_bitCnt   <= 3'd0;
            r_timer    <= 16'd0;
            r_divLatch <= 16'd0;
        end else begin
            r_state    <= w_nextState;
            r_txd      <= w_txdNext;
            r_shift    <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
            r_timer    <= w_timerNext;
            r_divLatch <= w_divLatchNext;
        end
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // FIFO storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= DIn[7:0];
    end

    // CPU-visible registers; hardware set of a sticky flag wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= DIV_RESET;
            r_ie     <= 1'b0;
            r_ipend  <= 1'b0;
            r_ovf    <= 1'b0;
            r_intReq <= 1'b0;
        end else begin
            if (w_wrCtrl) r_ie  <= DIn[0];
            if (w_wrDiv)  r_div <= DIn[15:0];
            if (w_setIpend)                 r_ipend <= 1'b1;
            else if (w_wrStatus && DIn[3])  r_ipend <= 1'b0;
            if (w_drop)                     r_ovf <= 1'b1;
            else if (w_wrStatus && DIn[4])  r_ovf <= 1'b0;
            r_intReq <= r_ipend & r_ie;
        end
    end

    // Combinational read mux.
    always_comb begin
        DOut = 32'd0;
        case (Addr)
            2'd1:    DOut = {27'd0, r_ovf, r_ipend, w_busy, w_empty, w_full};
            2'd2:    DOut = {31'd0, r_ie};
            2'd3:    DOut = {16'd0, r_div};
            default: DOut = 32'd0;
        endcase
    end

    assign TxD    = r_txd;
    assign IntReq = r_intReq;

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: register vectors, hand-written corner sequences and random
// frame streams compared against an arithmetic model of the serial line.
module tb_uart_tx_dev;
    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IntReq;
    logic        TxD;

    int errCount = 0;
    int checkCount = 0;
    int cycle = 0;

    logic [7:0] frByte [8];
    int         frDiv  [8];
    logic [1:0] wrAddr [8];
    logic [31:0] wrData [8];

    typedef struct {
        string       name;
        logic        doWrite;
        logic [1:0]  wAddr;
        logic [31:0] wData;
        logic [1:0]  rAddr;
        logic [31:0] expData;
    } vec_t;
    vec_t vecQ[$];

    uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd5208)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .DIn(DIn),
        .DOut(DOut), .IntReq(IntReq), .TxD(TxD)
    );

    // Free-running clock and edge counter used to time frames.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something never terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input string n, input logic w, input logic [1:0] wa,
                                   input logic [31:0] wd, input logic [1:0] ra, input logic [31:0] e);
        vec_t v;
        v.name = n; v.doWrite = w; v.wAddr = wa; v.wData = wd; v.rAddr = ra; v.expData = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    // Expected line level and busy flag idx clocks after the first frame starts.
    function automatic void modelLine(input int idx, input int nFr, output logic txd, output logic busy);
        int start;
        int len;
        int pos;
        logic [7:0] b;
        txd = 1'b1;
        busy = 1'b0;
        start = 0;
        if (idx < 0) return;
        for (int f = 0; f < nFr; f++) begin
            len = 10 * frDiv[f];
            if (idx >= start && idx < start + len) begin
                pos = (idx - start) / frDiv[f];
                b = frByte[f];
                busy = 1'b1;
                if (pos == 0)      txd = 1'b0;
                else if (pos == 9) txd = 1'b1;
                else               txd = b[pos-1];
            end
            start += len;
        end
    endfunction

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b1;
        Addr = 2'd0; DIn = 32'h77; WE = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        Addr = 2'd1;
        #1;
        checkOutput("relIgnoreWrite", DOut, 32'h2);
        repeat (3) @(negedge clk);
        checkOutput("relIdleTxd", 32'(TxD), 32'h1);
    endtask

    task automatic pulseReset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        Addr = 2'd1;
        #1;
        checkOutput({tag, "RstTxd"}, 32'(TxD), 32'h1);
        checkOutput({tag, "RstIntReq"}, 32'(IntReq), 32'h0);
        checkOutput({tag, "RstStatus"}, DOut, 32'h2);
        Addr = 2'd3;
        #1;
        checkOutput({tag, "RstDiv"}, DOut, 32'd5208);
        repeat (2) @(negedge clk);
        releaseReset();
    endtask

    task automatic prepStream(input int div, input bit ie);
        applyStimulus(2'd1, 32'h18);
        applyStimulus(2'd2, {31'd0, ie});
        applyStimulus(2'd3, 32'(div));
    endtask

    // Issue nWr writes on consecutive edges, then follow the line clock by clock.
    task automatic runStream(input int nWr, input int nFr, input bit ie);
        int k1;
        int t;
        int total;
        logic eTx;
        logic eBusy;
        total = 0;
        k1 = 0;
        for (int f = 0; f < nFr; f++) total += 10 * frDiv[f];
        for (int i = 0; i < nWr; i++) begin
            applyStimulus(wrAddr[i], wrData[i]);
            if (i == 0) k1 = cycle;
        end
        Addr = 2'd1;
        t = cycle - k1;
        while (t < total + 3) begin
            @(negedge clk);
            t = cycle - k1;
            modelLine(t - 1, nFr, eTx, eBusy);
            checkOutput($sformatf("txd@%0d", t), 32'(TxD), 32'(eTx));
            checkOutput($sformatf("busy@%0d", t), 32'(DOut[2]), 32'(eBusy));
            checkOutput($sformatf("ipend@%0d", t), 32'(DOut[3]), 32'(t >= total + 1));
            checkOutput($sformatf("intReq@%0d", t), 32'(IntReq), 32'(ie && (t >= total + 2)));
        end
    endtask

    initial begin
        int k1;
        int n;
        int d;
        int bad;
        bit ie;
        logic eTx;
        logic eBusy;

        reset = 1'b1; WE = 1'b0; Addr = 2'd1; DIn = 32'd0;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("asyncRstTxd", 32'(TxD), 32'h1);
        checkOutput("asyncRstIntReq", 32'(IntReq), 32'h0);
        checkOutput("asyncRstStatus", DOut, 32'h2);
        repeat (2) @(negedge clk);
        releaseReset();

        vecQ.push_back(mkVec("rdStatus",   1'b0, 2'd0, 32'h0,        2'd1, 32'h2));
        vecQ.push_back(mkVec("rdCtrl",     1'b0, 2'd0, 32'h0,        2'd2, 32'h0));
        vecQ.push_back(mkVec("rdDivRst",   1'b0, 2'd0, 32'h0,        2'd3, 32'd5208));
        vecQ.push_back(mkVec("rdData",     1'b0, 2'd0, 32'h0,        2'd0, 32'h0));
        vecQ.push_back(mkVec("ctrlSet",    1'b1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h1));
        vecQ.push_back(mkVec("ctrlClr",    1'b1, 2'd2, 32'hFFFFFFFE, 2'd2, 32'h0));
        vecQ.push_back(mkVec("divTrunc",   1'b1, 2'd3, 32'hABCD1234, 2'd3, 32'h1234));
        vecQ.push_back(mkVec("statusRO",   1'b1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'h2));
        vecQ.push_back(mkVec("divZero",    1'b1, 2'd3, 32'h0,        2'd3, 32'h0));
        vecQ.push_back(mkVec("dataReads0", 1'b0, 2'd0, 32'h0,        2'd0, 32'h0));
        foreach (vecQ[i]) begin
            if (vecQ[i].doWrite) applyStimulus(vecQ[i].wAddr, vecQ[i].wData);
            Addr = vecQ[i].rAddr;
            #1;
            checkOutput(vecQ[i].name, DOut, vecQ[i].expData);
        end

        $display("[TB] single frame 0x55, divisor 4");
        prepStream(4, 1'b0);
        frByte[0] = 8'h55; frDiv[0] = 4;
        wrAddr[0] = 2'd0; wrData[0] = 32'h55;
        runStream(1, 1, 1'b0);

        $display("[TB] four back-to-back frames, divisor 2, interrupts on");
        prepStream(2, 1'b1);
        frByte[0] = 8'hA5; frByte[1] = 8'h3C; frByte[2] = 8'hFF; frByte[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            frDiv[i] = 2; wrAddr[i] = 2'd0; wrData[i] = {24'd0, frByte[i]};
        end
        runStream(4, 4, 1'b1);
        applyStimulus(2'd1, 32'h8);
        Addr = 2'd1;
        #1;
        checkOutput("ipendCleared", 32'(DOut[3]), 32'h0);
        checkOutput("intReqLagsClear", 32'(IntReq), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("intReqFalls", 32'(IntReq), 32'h0);

        $display("[TB] zero divisor then mid-frame divisor change");
        prepStream(0, 1'b0);
        frByte[0] = 8'h96; frByte[1] = 8'h3B; frDiv[0] = 1; frDiv[1] = 3;
        wrAddr[0] = 2'd0; wrData[0] = 32'h96;
        wrAddr[1] = 2'd0; wrData[1] = 32'h3B;
        wrAddr[2] = 2'd3; wrData[2] = 32'h3;
        runStream(3, 2, 1'b0);

        $display("[TB] random streams");
        for (int it = 0; it < 6; it++) begin
            n  = $urandom_range(4, 1);
            d  = $urandom_range(3, 0);
            ie = 1'($urandom_range(1, 0));
            prepStream(d, ie);
            for (int i = 0; i < n; i++) begin
                frByte[i] = 8'($urandom);
                frDiv[i]  = (d == 0) ? 1 : d;
                wrAddr[i] = 2'd0;
                wrData[i] = {24'd0, frByte[i]};
            end
            runStream(n, n, ie);
        end

        $display("[TB] push on full coinciding with a STOP-end pop");
        prepStream(2, 1'b0);
        applyStimulus(2'd0, 32'h11);
        k1 = cycle;
        for (int i = 0; i < 4; i++) applyStimulus(2'd0, 32'(8'h20 + i));
        Addr = 2'd1;
        #1;
        checkOutput("fullAfter4", DOut, 32'h05);
        while (cycle < k1 + 20) @(negedge clk);
        checkOutput("fullBeforePop", DOut, 32'h05);
        applyStimulus(2'd0, 32'h33);
        Addr = 2'd1;
        #1;
        checkOutput("pushOnPopAccepted", DOut, 32'h05);
        applyStimulus(2'd0, 32'h44);
        Addr = 2'd1;
        #1;
        checkOutput("pushNoPopDropped", DOut, 32'h15);
        pulseReset("r35");

        $display("[TB] overflow with divisor 8");
        prepStream(8, 1'b0);
        applyStimulus(2'd0, 32'h01);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) applyStimulus(2'd0, 32'(8'h40 + i));
        Addr = 2'd1;
        #1;
        checkOutput("ovfFull", DOut, 32'h05);
        applyStimulus(2'd0, 32'h99);
        Addr = 2'd1;
        #1;
        checkOutput("ovfSet", DOut, 32'h15);
        applyStimulus(2'd1, 32'h10);
        Addr = 2'd1;
        #1;
        checkOutput("ovfCleared", DOut, 32'h05);
        pulseReset("r32");

        $display("[TB] reset during data bit 3 with two bytes queued");
        prepStream(4, 1'b0);
        frByte[0] = 8'h00; frDiv[0] = 4;
        applyStimulus(2'd0, 32'h00);
        k1 = cycle;
        applyStimulus(2'd0, 32'hAA);
        applyStimulus(2'd0, 32'h55);
        while (cycle < k1 + 18) @(negedge clk);
        modelLine(cycle - k1 - 1, 1, eTx, eBusy);
        checkOutput("midFrameTxd", 32'(TxD), 32'(eTx));
        #2;
        reset = 1'b0;
        Addr = 2'd1;
        #1;
        checkOutput("abortTxd", 32'(TxD), 32'h1);
        checkOutput("abortStatus", DOut, 32'h2);
        checkOutput("abortIntReq", 32'(IntReq), 32'h0);
        repeat (2) @(negedge clk);
        releaseReset();
        Addr = 2'd1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || DOut[2] !== 1'b0) bad++;
        end
        checkOutput("quietAfterAbort", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
